// File: rtl/fc_inter_layer_buffer.sv
// Activation stage between two fully-connected layers: ReLU, rounded requantisation and
// saturation, followed by a FWFT FIFO with vector framing toward the next layer's ifm port.
module fc_inter_layer_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IFM_WIDTH  = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned VEC_LEN    = 30,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [3:0]                    cfg_shift,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          in_valid,
  output logic signed [IFM_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          vec_last,
  output logic                          vec_done,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  // Saturation bounds expressed at the internal DATA_WIDTH+1 precision.
  localparam logic signed [DATA_WIDTH:0] SatMax =
    {{(DATA_WIDTH - IFM_WIDTH + 2){1'b0}}, {(IFM_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SatMin = ~SatMax;

  logic signed [DATA_WIDTH:0] x_ext, x_relu, rnd_add, x_sum, x_shr;
  logic signed [IFM_WIDTH-1:0] proc_data;

  logic                        stage_valid_q;
  logic signed [IFM_WIDTH-1:0] stage_data_q;
  logic signed [IFM_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic [CW-1:0]               elem_q;
  logic                        vec_done_q, overflow_q;

  logic pop, push, drop, elem_wrap;

  always_comb begin
    x_ext   = {in_data[DATA_WIDTH-1], in_data};
    x_relu  = (RELU_EN && x_ext[DATA_WIDTH]) ? '0 : x_ext;
    rnd_add = '0;
    if (cfg_shift != 4'd0) begin
      rnd_add = (DATA_WIDTH + 1)'(1) << (cfg_shift - 4'd1);
    end
    x_sum = x_relu + rnd_add;
    x_shr = x_sum >>> cfg_shift;
    if (x_shr > SatMax) begin
      proc_data = SatMax[IFM_WIDTH-1:0];
    end else if (x_shr < SatMin) begin
      proc_data = SatMin[IFM_WIDTH-1:0];
    end else begin
      proc_data = x_shr[IFM_WIDTH-1:0];
    end
  end

  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push      = stage_valid_q & (~full | pop);
    drop      = stage_valid_q & full & ~pop;
    elem_wrap = (elem_q == CW'(VEC_LEN - 1));
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    vec_last  = out_valid & elem_wrap;
    vec_done  = vec_done_q;
    level     = level_q;
    overflow  = overflow_q;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      elem_q        <= '0;
      vec_done_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (clr) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      elem_q        <= '0;
      vec_done_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      stage_valid_q <= in_valid;
      if (in_valid) begin
        stage_data_q <= proc_data;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        elem_q   <= elem_wrap ? '0 : elem_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      vec_done_q <= pop & elem_wrap;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk1) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q] <= stage_data_q;
    end
  end

endmodule

// File: tb/tb_fc_inter_layer_buffer.sv
// Scoreboard bench for fc_inter_layer_buffer: a 16-bit and an 8-bit output instance share
// stimulus; an arithmetic reference model feeds an expected-value queue checked by a monitor.
module tb_fc_inter_layer_buffer;

  localparam int DEPTH   = 32;
  localparam int VEC_LEN = 30;

  logic               clk1, rst_n, clr, in_valid, out_ready;
  logic [3:0]         cfg_shift;
  logic signed [15:0] in_data;
  logic signed [15:0] out_data;
  logic signed [7:0]  out_data8;
  logic               out_valid, vec_last, vec_done, full, overflow;
  logic               out_valid8, vec_last8, vec_done8, full8, overflow8;
  logic [5:0]         level, level8;

  fc_inter_layer_buffer #(
    .DATA_WIDTH(16), .IFM_WIDTH(16), .DEPTH(DEPTH), .VEC_LEN(VEC_LEN), .RELU_EN(1'b1)
  ) u_dut (
    .clk1(clk1), .rst_n(rst_n), .clr(clr), .cfg_shift(cfg_shift), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .vec_last(vec_last), .vec_done(vec_done), .level(level), .full(full), .overflow(overflow)
  );

  fc_inter_layer_buffer #(
    .DATA_WIDTH(16), .IFM_WIDTH(8), .DEPTH(DEPTH), .VEC_LEN(VEC_LEN), .RELU_EN(1'b1)
  ) u_dut8 (
    .clk1(clk1), .rst_n(rst_n), .clr(clr), .cfg_shift(cfg_shift), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready),
    .vec_last(vec_last8), .vec_done(vec_done8), .level(level8), .full(full8),
    .overflow(overflow8)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct { int v16; int v8; } exp_t;

  exp_t exp_q[$];
  exp_t m_stage;
  int   m_occ, m_elem;
  bit   m_stage_v, m_ovf, m_done;
  int   n_checks, n_err, done_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ReLU, round-half-up divide by 2^sh, clamp to an iw-bit signed range.
  function automatic int ref_proc(input int x, input int sh, input int iw);
    int v, mx, mn;
    v  = x;
    mx = (1 << (iw - 1)) - 1;
    mn = -(1 << (iw - 1));
    if (v < 0) v = 0;
    if (sh > 0) v = (v + (1 << (sh - 1))) / (1 << sh);
    if (v > mx) v = mx;
    if (v < mn) v = mn;
    return v;
  endfunction

  // Reference model: a bounded queue plus one staging slot.
  initial begin
    m_occ = 0; m_elem = 0; m_stage_v = 0; m_ovf = 0; m_done = 0;
    forever begin
      @(posedge clk1 or negedge rst_n);
      if (!rst_n || clr) begin
        m_occ = 0; m_elem = 0; m_stage_v = 0; m_ovf = 0; m_done = 0;
        exp_q.delete();
      end else begin
        bit pop;
        pop    = (m_occ > 0) && out_ready;
        m_done = pop && (m_elem == VEC_LEN - 1);
        if (pop) begin
          m_occ--;
          m_elem = (m_elem + 1) % VEC_LEN;
        end
        if (m_stage_v) begin
          if (m_occ < DEPTH) begin
            exp_q.push_back(m_stage);
            m_occ++;
          end else begin
            m_ovf = 1;
          end
        end
        m_stage_v = in_valid;
        if (in_valid) begin
          m_stage.v16 = ref_proc(int'(in_data), int'(cfg_shift), 16);
          m_stage.v8  = ref_proc(int'(in_data), int'(cfg_shift), 8);
        end
      end
    end
  end

  // Monitor: mid-cycle comparison of the DUT against the model and scoreboard.
  initial begin
    forever begin
      @(negedge clk1);
      if (rst_n) begin
        chk("out_valid", int'(out_valid), int'(m_occ > 0));
        chk("out_valid8", int'(out_valid8), int'(m_occ > 0));
        chk("level", int'(level), m_occ);
        chk("level8", int'(level8), m_occ);
        chk("full", int'(full), int'(m_occ == DEPTH));
        chk("full8", int'(full8), int'(m_occ == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("overflow8", int'(overflow8), int'(m_ovf));
        chk("vec_last", int'(vec_last), int'(m_occ > 0 && m_elem == VEC_LEN - 1));
        chk("vec_last8", int'(vec_last8), int'(m_occ > 0 && m_elem == VEC_LEN - 1));
        chk("vec_done", int'(vec_done), int'(m_done));
        chk("vec_done8", int'(vec_done8), int'(m_done));
        if (vec_done) done_cnt++;
        if (out_valid) begin
          chk("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            chk("out_data", int'(out_data), exp_q[0].v16);
            chk("out_data8", int'(out_data8), exp_q[0].v8);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_data", int'(out_data), 0);
          chk("idle_data8", int'(out_data8), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((m_occ > 0 || m_stage_v) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", m_occ, 0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_vec_last"}, int'(vec_last), 0);
    chk({tag, "_vec_done"}, int'(vec_done), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_shift = 4'd0; n_checks = 0; n_err = 0; done_cnt = 0;
    repeat (2) @(posedge clk1);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Passthrough with ReLU.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'sd5;     tick();
    in_data = -16'sd3;    tick();
    in_data = 16'sd32767; tick();
    idle(5);

    // Rounding (and 8-bit saturation on the second instance).
    cfg_shift = 4'd2;
    in_valid = 1'b1;
    in_data = 16'sd6;     tick();
    in_data = 16'sd5;     tick();
    in_data = 16'sd32767; tick();
    drain();
    cfg_shift = 4'd0;

    // Fill to full, push+pop at full, then overflow.
    clr_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      tick();
    end
    idle(2);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), DEPTH);
    chk("fill_no_ovf", int'(overflow), 0);
    in_valid = 1'b1; in_data = 16'sd1234; tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("pushpop_level", int'(level), DEPTH);
    chk("pushpop_no_ovf", int'(overflow), 0);
    in_valid = 1'b1;
    in_data = 16'sd77; tick();
    in_data = 16'sd88; tick();
    idle(2);
    chk("ovf_set", int'(overflow), 1);
    drain();
    chk("ovf_sticky", int'(overflow), 1);
    clr_pulse();
    chk("ovf_clr", int'(overflow), 0);

    // Clear mid-stream with a push in flight and a partly advanced element counter.
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom_range(0, 32767)); tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("pre_clr_level", int'(level), 10);
    in_valid = 1'b1; in_data = 16'sd99; clr = 1'b1; tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_level", int'(level), 0);
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_out_data", int'(out_data), 0);
    tick();
    chk("clr_discard", int'(level), 0);

    // Vector framing over two vectors with random backpressure.
    d0 = done_cnt;
    for (int i = 0; i < 2 * VEC_LEN; i++) begin
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    idle(2);
    chk("vec_done_pulses", done_cnt - d0, 2);

    // Randomised traffic; shift changes only once the pipeline is empty.
    for (int blk = 0; blk < 6; blk++) begin
      cfg_shift = 4'($urandom_range(0, 15));
      if (blk < 3) cfg_shift = 4'($urandom_range(0, 4));
      for (int i = 0; i < 250; i++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_data   = 16'($urandom);
        out_ready = ($urandom_range(0, 9) < 6);
        clr       = ($urandom_range(0, 199) == 0);
        tick();
      end
      clr = 1'b0;
      drain();
    end
    cfg_shift = 4'd0;

    // Asynchronous reset mid-cycle with data buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom_range(1, 32767)); tick();
    end
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'sd42; tick();
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_inter_layer_buffer.md
# fc_inter_layer_buffer

Elastic activation stage between two fully-connected `TOP` instances. It consumes the upstream layer's `ofm`/`valid_data` stream and applies ReLU, rounded requantisation and saturation. Results are buffered in a first-word-fall-through FIFO and replayed to the downstream layer's `ifm`/`valid_ifm` port under a ready handshake. It also marks the last element of each output vector.

## Interface
Parameters:
- DATA_WIDTH, 16, width of incoming signed `ofm` sample
- IFM_WIDTH, 16, width of outgoing signed `ifm` sample (must be ≤ DATA_WIDTH)
- DEPTH, 32, FIFO entries; must be a power of 2, ≥ 4
- VEC_LEN, 30, elements per vector, equal to the downstream IFM_SIZE
- RELU_EN, 1, 1 = clamp negatives to 0

Ports:
- clk1  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of datapath, FIFO, counters and flags
- cfg_shift  in  4  arithmetic right-shift amount (0–15); sample only while FIFO and stage are empty
- in_data  in  DATA_WIDTH  signed sample from upstream `ofm`
- in_valid  in  1  upstream `valid_data`; no backpressure exists
- out_data  out  IFM_WIDTH  FIFO head; forced to 0 when `out_valid`=0
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts head this cycle
- vec_last  out  1  head is element VEC_LEN-1 of the current vector (qualified by `out_valid`)
- vec_done  out  1  one-cycle registered pulse after the last element of a vector is popped
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- full  out  1  level == DEPTH
- overflow  out  1  sticky; a processed sample was dropped

## Operation
- Stage 1 (register, always advances):
  - On `in_valid`, capture the processed value and set the stage-valid bit.
  - Otherwise clear the stage-valid bit.
- Processing, all in signed arithmetic at DATA_WIDTH+1 bits:
  - x = in_data.
  - If RELU_EN and x < 0, then x = 0.
  - If cfg_shift > 0: x = (x + 2^(cfg_shift-1)) >>> cfg_shift (round half up).
  - Saturate to [−2^(IFM_WIDTH-1), 2^(IFM_WIDTH-1)−1].
- Push:
  - When stage-valid, write to the FIFO if `!full`, or if `full` with a pop in the same cycle.
  - Otherwise drop the sample and set `overflow`.
- Pop: `out_valid && out_ready`. `out_ready` while `!out_valid` is ignored.
- Simultaneous push and pop: `level` is unchanged; pointers both advance.
- Pointers wrap modulo DEPTH.
- Element counter:
  - 0..VEC_LEN-1; increments on each pop.
  - On a pop at VEC_LEN-1 it wraps to 0 and `vec_done` pulses on the next cycle.
  - Dropped samples are not counted.
- `vec_last` = `out_valid` && (element counter == VEC_LEN-1).
- `clr` overrides any same-cycle push or pop:
  - Clears the pointers, `level`, stage-valid, element counter, `overflow` and `vec_done`.
  - The sample in stage 1 at that edge is discarded.
- Reset values: out_valid 0, out_data 0, vec_last 0, vec_done 0, level 0, full 0, overflow 0. Pointers, counter and stage-valid are all 0.
- Reset mid-operation: all contents are discarded immediately (asynchronous); no partial vector survives.

## Timing
- Input latency: sample with `in_valid` at edge N is registered in stage 1 at N and written to the FIFO at N+1. `out_valid` and `out_data` are valid after N+1 when the FIFO was empty, i.e. 2 cycles in to out.
- Output is FWFT: `out_data` is combinational from the head entry and is stable while `out_valid && !out_ready`.
- `level`, `full` and `overflow` update on the same edge as the push or pop that changes them.
- `vec_done` is asserted in the cycle after the popping edge, for one cycle only.
- Sustained throughput: 1 sample/cycle in and out.

## Test plan
- Passthrough: cfg_shift=0, RELU_EN=1, out_ready=1; input 5, −3, 32767 back-to-back → outputs 5, 0, 32767 appear 2 cycles after each input; level peaks at 1.
- Rounding and saturation: cfg_shift=2; inputs 6, 5, 32767. Expected outputs 2, 1, 8192; with IFM_WIDTH=8 the outputs become 2, 1, 127.
- Fill/overflow: out_ready=0, DEPTH=32; push 34 samples. Expected: full=1 after 32, overflow=1, level=32. Then drain with out_ready=1: the first 32 values pop in order and overflow stays 1 until `clr`.
- Full with simultaneous push/pop: at level=32, push and pop in the same cycle → no overflow, level stays 32, the new value lands at the tail.
- Vector framing: VEC_LEN=30; stream 60 samples with random out_ready. Expected: vec_last on heads #29 and #59, and vec_done pulses exactly twice, each one cycle after the pop of #29 and of #59.
- Clear/reset mid-stream: with level=10, assert clr during a push → level=0, out_valid=0, out_data=0, counter=0. Repeat with rst_n low asynchronously mid-cycle: all outputs reach their reset values immediately.
